regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of a register.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, number of denied cycles before ex_hold asserts.
REQ-003 SHALL have port sys_clk  input  1  clock, rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_wen  input  1  single-cycle execute write request (cannot stall).
REQ-006 SHALL have port ex_waddr / ex_wdata  input  5 / XLEN  execute write address / data.
REQ-007 SHALL have port div_valid, div_ready  input, output  1 each  divider result handshake.
REQ-008 SHALL have port div_waddr / div_wdata  input  5 / XLEN  divider result address / data.
REQ-009 SHALL have port mem_valid, mem_ready  input, output  1 each  load-return handshake.
REQ-010 SHALL have port mem_waddr / mem_wdata  input  5 / XLEN  load address / data.
REQ-011 SHALL have port issue_valid, issue_ready  input, output  1 each  long-latency op issue (divide or load).
REQ-012 SHALL have port issue_rd  input  5  destination of the issued op.
REQ-013 SHALL have port rs1_addr, rs2_addr, rd_addr  input  5 each  decode busy queries.
REQ-014 SHALL have port rs1_busy, rs2_busy, rd_busy  output  1 each  query results.
REQ-015 SHALL have port ex_hold  output  1  tells decode to withhold an execute write next cycle.
REQ-016 SHALL have port reg_wen / reg_waddr / reg_wdata  output  1 / 5 / XLEN  register file write port.

Function
REQ-017 Write port SHALL be combinational from the current requests: zero-cycle latency, no output register.
REQ-018 ex request (ex_wen=1) SHALL always win the port; div_ready and mem_ready SHALL then be 0.
REQ-019 Without an ex request, div and mem SHALL be arbitrated round-robin; a 1-bit pointer SHALL favour div after reset and flip to the non-winner after each div/mem grant.
REQ-020 A grant SHALL occur iff valid and ready are both 1; the winner's address/data SHALL drive reg_waddr/reg_wdata with reg_wen=1.
REQ-021 A grant with waddr=0 SHALL complete the handshake with reg_wen forced to 0.
REQ-022 With no grant, reg_wen SHALL be 0 and reg_waddr/reg_wdata SHALL be 0.
REQ-023 Scoreboard: 32 busy bits; issue_valid & issue_ready with issue_rd!=0 SHALL set busy[issue_rd] at the next edge; issue_rd=0 SHALL set nothing.
REQ-024 issue_ready SHALL be 0 when busy[issue_rd]=1 (no WAW between long-latency ops), else 1.
REQ-025 A div or mem grant SHALL clear busy[waddr] at the next edge; a set and a clear of different registers in the same cycle SHALL both take effect.
REQ-026 rsN_busy/rd_busy SHALL equal the busy bit, but SHALL be 0 when address=0 or when a div/mem grant to that address occurs in the same cycle (register file forwards it).
REQ-027 Starvation counter: SHALL increment each cycle some of div_valid/mem_valid is 1 with no div/mem grant; SHALL clear on any div/mem grant or when neither valid is 1; SHALL saturate at STARVE_LIMIT.
REQ-028 ex_hold SHALL be registered, 1 while counter = STARVE_LIMIT, dropping the cycle after a div/mem grant.
REQ-029 ex_wen asserted while ex_hold=1 SHALL still win (REQ-018); honouring ex_hold is decode's duty.

Reset
REQ-030 On sys_rst_n=0, asynchronously: busy bits 0, RR pointer to div, starvation counter 0, ex_hold 0.
REQ-031 While sys_rst_n=0, reg_wen, div_ready, mem_ready, issue_ready and all busy outputs SHALL be 0; in-flight handshakes are dropped.

Structure
REQ-032 XLEN default, register address width (5) and the requester encoding (EX, DIV, MEM) SHALL live in the shared package riscv_pkg.
REQ-033 The 32-bit busy table with set/clear/query logic SHALL be one sub-module, reg_scoreboard; arbitration and starvation logic stay in the top.

Verification
REQ-034 ex_wen=1 to x5=0x11 with div_valid=1 to x6 -> reg_waddr=5, reg_wdata=0x11, div_ready=0; next cycle with ex idle -> x6 written.
REQ-035 div_valid and mem_valid held for 4 cycles after reset -> grant order div, mem, div, mem.
REQ-036 Issue rd=7 -> rd_busy(7)=1 next cycle; second issue to rd=7 sees issue_ready=0; mem grant to x7 -> rs1_busy(7)=0 the same cycle, busy bit cleared next cycle.
REQ-037 ex_wen=1 every cycle with mem_valid=1 -> ex_hold=1 after 4 denied cycles; drop ex_wen -> mem granted, ex_hold=0 next cycle.
REQ-038 div grant to x0 -> div_ready=1, reg_wen=0; issue_rd=0 -> no busy bit set.
REQ-039 Busy bits set on x3 and x9, then sys_rst_n pulsed low mid-handshake -> all busy 0, all ready 0, and the RR pointer favours div again.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: data/address widths and write-back requester encoding.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  // Which requester owns the register file write port this cycle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_EX   = 2'd1,
    REQ_DIV  = 2'd2,
    REQ_MEM  = 2'd3
  } req_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy table for long-latency destinations: set on issue, clear on write-back,
// queried combinationally by decode with same-cycle write-back forwarding.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // x0 is never busy; a register being written back this cycle is forwarded.
  function automatic logic busy_query(input logic [NUM_REGS-1:0] tbl,
                                      input logic [REG_AW-1:0]   addr,
                                      input logic                wb_valid,
                                      input logic [REG_AW-1:0]   wb_addr);
    return (addr != '0) && tbl[addr] && !(wb_valid && (wb_addr == addr));
  endfunction

  // Issue handshake, busy queries and next busy table (a new issue overrides a clear).
  always_comb begin
    issue_ready = sys_rst_n && !busy_q[issue_rd];
    rs1_busy    = busy_query(busy_q, rs1_addr, clr_valid, clr_addr);
    rs2_busy    = busy_query(busy_q, rs2_addr, clr_valid, clr_addr);
    rd_busy     = busy_query(busy_q, rd_addr,  clr_valid, clr_addr);
    busy_d      = busy_q;
    if (clr_valid && (clr_addr != '0)) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Busy table register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-back arbiter: execute has absolute priority, divider and
// load returns share the port round-robin, with a starvation hint to decode.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [REG_AW-1:0] div_waddr,
  input  logic [XLEN-1:0]   div_wdata,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              ex_hold,
  output logic              reg_wen,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [XLEN-1:0]   reg_wdata
);

  localparam int unsigned       CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  req_e             winner;
  logic             dm_grant;
  logic             rr_mem_q, rr_mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_hold_q, ex_hold_d;

  // Pick the port owner: ex first, then div/mem by the round-robin pointer.
  always_comb begin
    winner    = REQ_NONE;
    div_ready = 1'b0;
    mem_ready = 1'b0;
    if (sys_rst_n) begin
      if (ex_wen) begin
        winner = REQ_EX;
      end else begin
        div_ready = !(mem_valid && rr_mem_q);
        mem_ready = !(div_valid && !rr_mem_q);
        if (div_valid && div_ready) begin
          winner = REQ_DIV;
        end else if (mem_valid && mem_ready) begin
          winner = REQ_MEM;
        end
      end
    end
  end

  // Steer the winner onto the write port; x0 handshakes complete without a write.
  always_comb begin
    reg_waddr = '0;
    reg_wdata = '0;
    unique case (winner)
      REQ_EX: begin
        reg_waddr = ex_waddr;
        reg_wdata = ex_wdata;
      end
      REQ_DIV: begin
        reg_waddr = div_waddr;
        reg_wdata = div_wdata;
      end
      REQ_MEM: begin
        reg_waddr = mem_waddr;
        reg_wdata = mem_wdata;
      end
      default: ;
    endcase
    reg_wen  = (winner != REQ_NONE) && (reg_waddr != '0);
    dm_grant = (winner == REQ_DIV) || (winner == REQ_MEM);
  end

  // Next pointer (favour the loser) and saturating starvation count.
  always_comb begin
    rr_mem_d = rr_mem_q;
    if (winner == REQ_DIV) begin
      rr_mem_d = 1'b1;
    end else if (winner == REQ_MEM) begin
      rr_mem_d = 1'b0;
    end
    cnt_d = cnt_q;
    if (dm_grant || !(div_valid || mem_valid)) begin
      cnt_d = '0;
    end else if (cnt_q != STARVE_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ex_hold_d = (cnt_d == STARVE_MAX);
  end

  // Arbitration state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_mem_q  <= 1'b0;
      cnt_q     <= '0;
      ex_hold_q <= 1'b0;
    end else begin
      rr_mem_q  <= rr_mem_d;
      cnt_q     <= cnt_d;
      ex_hold_q <= ex_hold_d;
    end
  end

  assign ex_hold = ex_hold_q;

  reg_scoreboard u_scoreboard (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_valid   (dm_grant),
    .clr_addr    (reg_waddr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed table, corner sequences, random vs model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        sys_clk, sys_rst_n;
  logic        ex_wen;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        div_valid, div_ready;
  logic [4:0]  div_waddr;
  logic [31:0] div_wdata;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        ex_hold;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .div_valid(div_valid), .div_ready(div_ready), .div_waddr(div_waddr), .div_wdata(div_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .ex_hold(ex_hold),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wen = 0; ex_waddr = 0; ex_wdata = 0;
    div_valid = 0; div_waddr = 0; div_wdata = 0;
    mem_valid = 0; mem_waddr = 0; mem_wdata = 0;
    issue_valid = 0; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  // Directed table: one row per cycle, starting straight after reset.
  typedef struct {
    logic        ex_v;  logic [4:0] ex_a;  logic [31:0] ex_d;
    logic        dv;    logic [4:0] da;    logic [31:0] dd;
    logic        mv;    logic [4:0] ma;    logic [31:0] md;
    logic        e_wen; logic [4:0] e_a;   logic [31:0] e_d;
    logic        e_dr;  logic       e_mr;  logic        chk_d;
  } vec_t;

  vec_t vecs[9];

  // Reference model state.
  bit m_busy[32];
  bit m_fav_div;
  int m_cnt;
  bit m_hold;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_fav_div = 1;
    m_cnt     = 0;
    m_hold    = 0;
  endtask

  function automatic bit m_query(input logic [4:0] a, input bit dm, input logic [4:0] ga);
    return (a != 0) && m_busy[int'(a)] && !(dm && ga == a);
  endfunction

  // Compare one cycle against the model, then advance the model.
  task automatic model_cycle();
    int          win;          // 0 none, 1 ex, 2 div, 3 mem
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          dm, ir;
    if (ex_wen) win = 1;
    else if (div_valid && mem_valid) win = m_fav_div ? 2 : 3;
    else if (div_valid) win = 2;
    else if (mem_valid) win = 3;
    else win = 0;
    case (win)
      1: begin ea = ex_waddr;  ed = ex_wdata;  end
      2: begin ea = div_waddr; ed = div_wdata; end
      3: begin ea = mem_waddr; ed = mem_wdata; end
      default: begin ea = 0; ed = 0; end
    endcase
    dm = (win == 2) || (win == 3);
    ir = !m_busy[int'(issue_rd)];
    chk("rand_reg_wen", 32'(reg_wen), 32'(win != 0 && ea != 0));
    chk("rand_reg_waddr", 32'(reg_waddr), 32'(ea));
    if (win == 0 || ea != 0) chk("rand_reg_wdata", reg_wdata, ed);
    if (div_valid || ex_wen) chk("rand_div_ready", 32'(div_ready), 32'(win == 2));
    if (mem_valid || ex_wen) chk("rand_mem_ready", 32'(mem_ready), 32'(win == 3));
    chk("rand_issue_ready", 32'(issue_ready), 32'(ir));
    chk("rand_rs1_busy", 32'(rs1_busy), 32'(m_query(rs1_addr, dm, ea)));
    chk("rand_rs2_busy", 32'(rs2_busy), 32'(m_query(rs2_addr, dm, ea)));
    chk("rand_rd_busy", 32'(rd_busy), 32'(m_query(rd_addr, dm, ea)));
    chk("rand_ex_hold", 32'(ex_hold), 32'(m_hold));
    if (dm && ea != 0) m_busy[int'(ea)] = 0;
    if (issue_valid && ir && issue_rd != 0) m_busy[int'(issue_rd)] = 1;
    if (win == 2) m_fav_div = 0;
    if (win == 3) m_fav_div = 1;
    if (dm || !(div_valid || mem_valid)) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt++;
    m_hold = (m_cnt == LIMIT);
  endtask

  initial begin
    // ex_v ex_a ex_d | dv da dd | mv ma md | e_wen e_a e_d | e_dr e_mr chk_d
    vecs[0] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd1, 32'hA1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1};

    // Outputs while reset is held, with every request active.
    sys_rst_n = 1'b0;
    idle_inputs();
    ex_wen = 1; ex_waddr = 5'd3; div_valid = 1; div_waddr = 5'd4; mem_valid = 1; mem_waddr = 5'd5;
    issue_valid = 1; issue_rd = 5'd6;
    #3;
    chk("rst_reg_wen", 32'(reg_wen), 0);
    chk("rst_div_ready", 32'(div_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_issue_ready", 32'(issue_ready), 0);
    chk("rst_ex_hold", 32'(ex_hold), 0);
    do_reset();

    // Directed table.
    foreach (vecs[i]) begin
      ex_wen = vecs[i].ex_v; ex_waddr = vecs[i].ex_a; ex_wdata = vecs[i].ex_d;
      div_valid = vecs[i].dv; div_waddr = vecs[i].da; div_wdata = vecs[i].dd;
      mem_valid = vecs[i].mv; mem_waddr = vecs[i].ma; mem_wdata = vecs[i].md;
      @(negedge sys_clk);
      chk($sformatf("vec%0d_reg_wen", i), 32'(reg_wen), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d_reg_waddr", i), 32'(reg_waddr), 32'(vecs[i].e_a));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_reg_wdata", i), reg_wdata, vecs[i].e_d);
      if (vecs[i].dv || vecs[i].ex_v) chk($sformatf("vec%0d_div_ready", i), 32'(div_ready), 32'(vecs[i].e_dr));
      if (vecs[i].mv || vecs[i].ex_v) chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
      tick();
    end

    // Round-robin order from reset with both requesters continuously valid.
    do_reset();
    div_valid = 1; div_waddr = 5'd10; mem_valid = 1; mem_waddr = 5'd20;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk($sformatf("rr_order%0d", k), 32'(reg_waddr), (k % 2 == 0) ? 32'd10 : 32'd20);
      tick();
    end

    // Scoreboard set, WAW block, forwarding, set+clear same cycle, x0 handling.
    do_reset();
    issue_valid = 1; issue_rd = 5'd7;
    @(negedge sys_clk);
    chk("sb_issue7_ready", 32'(issue_ready), 1);
    tick();
    rd_addr = 5'd7;
    @(negedge sys_clk);
    chk("sb_rd_busy7", 32'(rd_busy), 1);
    chk("sb_waw_block", 32'(issue_ready), 0);
    tick();
    issue_rd = 5'd9; mem_valid = 1; mem_waddr = 5'd7; mem_wdata = 32'h77; rs1_addr = 5'd7;
    @(negedge sys_clk);
    chk("sb_fwd_rs1", 32'(rs1_busy), 0);
    chk("sb_fwd_rd", 32'(rd_busy), 0);
    chk("sb_mem_ready", 32'(mem_ready), 1);
    chk("sb_mem_wen", 32'(reg_wen), 1);
    tick();
    issue_valid = 0; issue_rd = 5'd7; mem_valid = 0; rs2_addr = 5'd9;
    @(negedge sys_clk);
    chk("sb_cleared7", 32'(rs1_busy), 0);
    chk("sb_set9", 32'(rs2_busy), 1);
    chk("sb_reissue7_ready", 32'(issue_ready), 1);
    tick();
    issue_valid = 1; issue_rd = 5'd0; div_valid = 1; div_waddr = 5'd0; div_wdata = 32'h5;
    @(negedge sys_clk);
    chk("x0_div_ready", 32'(div_ready), 1);
    chk("x0_reg_wen", 32'(reg_wen), 0);
    tick();
    issue_valid = 0; div_valid = 0;
    @(negedge sys_clk);
    chk("x0_not_busy", 32'(issue_ready), 1);
    tick();

    // Starvation: ex hogs the port while mem waits.
    do_reset();
    ex_wen = 1; ex_waddr = 5'd1; mem_valid = 1; mem_waddr = 5'd12; mem_wdata = 32'hC;
    @(negedge sys_clk);
    chk("starve_hold0", 32'(ex_hold), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge sys_clk);
      chk($sformatf("starve_hold_after%0d", k), 32'(ex_hold), (k >= LIMIT) ? 32'd1 : 32'd0);
    end
    tick();
    ex_wen = 0;
    @(negedge sys_clk);
    chk("starve_mem_granted", 32'(mem_ready), 1);
    chk("starve_mem_addr", 32'(reg_waddr), 12);
    chk("starve_hold_still", 32'(ex_hold), 1);
    tick();
    mem_valid = 0;
    @(negedge sys_clk);
    chk("starve_hold_drop", 32'(ex_hold), 0);
    tick();

    // Asynchronous reset in the middle of a handshake.
    do_reset();
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 0; issue_rd = 5'd3; div_valid = 1; div_waddr = 5'd20;
    tick();
    div_waddr = 5'd3; mem_valid = 1; mem_waddr = 5'd9; rs2_addr = 5'd9; rd_addr = 5'd3;
    @(negedge sys_clk);
    chk("prerst_mem_favoured", 32'(mem_ready), 1);
    chk("prerst_busy3", 32'(issue_ready), 0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_rs2_busy", 32'(rs2_busy), 0);
    chk("midrst_rd_busy", 32'(rd_busy), 0);
    chk("midrst_div_ready", 32'(div_ready), 0);
    chk("midrst_mem_ready", 32'(mem_ready), 0);
    chk("midrst_issue_ready", 32'(issue_ready), 0);
    chk("midrst_reg_wen", 32'(reg_wen), 0);
    tick();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("postrst_busy9", 32'(rs2_busy), 0);
    chk("postrst_busy3", 32'(issue_ready), 1);
    chk("postrst_div_favoured", 32'(div_ready), 1);
    chk("postrst_mem_denied", 32'(mem_ready), 0);
    chk("postrst_waddr", 32'(reg_waddr), 3);
    tick();

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ex_wen      = ($urandom_range(99, 0) < (((cyc / 64) % 2 == 1) ? 90 : 25));
      ex_waddr    = 5'($urandom_range(31, 1));
      ex_wdata    = $urandom();
      div_valid   = ($urandom_range(1, 0) == 1);
      div_waddr   = 5'($urandom_range(11, 0));
      div_wdata   = $urandom();
      mem_valid   = ($urandom_range(1, 0) == 1);
      mem_waddr   = 5'($urandom_range(11, 0));
      mem_wdata   = $urandom();
      issue_valid = ($urandom_range(99, 0) < 40);
      issue_rd    = 5'($urandom_range(11, 0));
      rs1_addr    = 5'($urandom_range(11, 0));
      rs2_addr    = 5'($urandom_range(11, 0));
      rd_addr     = 5'($urandom_range(11, 0));
      @(negedge sys_clk);
      model_cycle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
